// File: rtl/sfifo_pkg.sv
// Shared definitions for the synchronous FIFO controllers.
// Default geometry plus pointer arithmetic common to both sides.
package sfifo_pkg;

  localparam int unsigned ADDR_LINES = 8;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned PTR_W      = ADDR_LINES + 1;

  // Modulo difference of two pointers that are w bits wide.
  function automatic logic [31:0] ptr_count(
    input logic [31:0] wr,
    input logic [31:0] rd,
    input int unsigned w
  );
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return (wr - rd) & mask;
  endfunction

endpackage

// File: rtl/sfifo_out_stage.sv
// First-word-fall-through head register with one-entry skid.
// Absorbs RAM read latency so the consumer sees zero-bubble pops.
module sfifo_out_stage
  import sfifo_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 land,
  input  logic                 req,
  input  logic [DataWidth-1:0] rd_data,
  output logic [DataWidth-1:0] dout,
  output logic                 valid,
  output logic                 skid_valid,
  output logic                 pop
);

  logic [DataWidth-1:0] skid;

  assign pop = req && valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dout       <= '0;
      skid       <= '0;
      valid      <= 1'b0;
      skid_valid <= 1'b0;
    end else if (land) begin
      if (!valid || (pop && !skid_valid)) begin
        dout  <= rd_data;
        valid <= 1'b1;
      end else if (pop) begin
        // Head drains from skid; new word refills skid.
        dout <= skid;
        skid <= rd_data;
      end else begin
        skid       <= rd_data;
        skid_valid <= 1'b1;
      end
    end else if (pop) begin
      if (skid_valid) begin
        dout       <= skid;
        skid_valid <= 1'b0;
      end else begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sfifo_rd_control.sv
// Read-side controller of the synchronous FIFO.
// Owns the read pointer, issues RAM reads, feeds the FWFT stage.
module sfifo_rd_control
  import sfifo_pkg::*;
#(
  parameter int AddrLines = ADDR_LINES,
  parameter int DataWidth = DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AddrLines:0]   SyncWrAddr,
  input  logic                 FIFORdReq,
  input  logic [DataWidth-1:0] RdData,
  output logic                 RdEn,
  output logic [AddrLines-1:0] RdAddr,
  output logic [AddrLines:0]   SyncRdAddr,
  output logic [DataWidth-1:0] FIFODout,
  output logic                 FIFOValid,
  output logic                 FIFOEmpty,
  output logic [AddrLines:0]   MemCount
);

  localparam int PtrW = AddrLines + 1;

  logic       rd_pend;
  logic       skid_valid;
  logic       pop;
  logic       mem_empty;
  logic [1:0] occ;
  logic [1:0] avail;

  assign mem_empty = (SyncWrAddr == SyncRdAddr);
  assign occ       = {1'b0, FIFOValid} + {1'b0, skid_valid}
                   + {1'b0, rd_pend};
  // A word leaving this cycle frees a slot for a read issued now.
  assign avail     = occ - {1'b0, pop};
  assign RdEn      = reset && !mem_empty && (avail < 2'd2);
  assign RdAddr    = SyncRdAddr[AddrLines-1:0];
  assign FIFOEmpty = !FIFOValid;
  assign MemCount  = PtrW'(ptr_count(32'(SyncWrAddr),
                                     32'(SyncRdAddr),
                                     PtrW));

  always_ff @(posedge clk) begin
    if (!reset) begin
      SyncRdAddr <= '0;
      rd_pend    <= 1'b0;
    end else begin
      rd_pend <= RdEn;
      if (RdEn) SyncRdAddr <= SyncRdAddr + 1'b1;
    end
  end

  sfifo_out_stage #(
    .DataWidth (DataWidth)
  ) u_out (
    .clk        (clk),
    .reset      (reset),
    .land       (rd_pend),
    .req        (FIFORdReq),
    .rd_data    (RdData),
    .dout       (FIFODout),
    .valid      (FIFOValid),
    .skid_valid (skid_valid),
    .pop        (pop)
  );

endmodule

// File: doc/sfifo_rd_control.md
Name: sfifo_rd_control

Overview:
Read-side controller for the synchronous FIFO. It is the counterpart of the write controller and sits beside it, sharing the dual-port RAM.
- Owns the extended read pointer and issues RAM reads.
- Hides the RAM's 1-cycle read latency behind a first-word-fall-through (FWFT) output stage: head data plus a skid register.
- Exports its pointer to the write side for full detection.
- Gives the consumer a valid/pop interface with zero-bubble streaming.

Parameters:
AddrLines, 8, RAM address width; depth = 2**AddrLines; pointers are AddrLines+1 bits (MSB = wrap bit)
DataWidth, 8, data word width

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
SyncWrAddr  input  AddrLines+1  write pointer from write controller, same clock domain
FIFORdReq  input  1  consumer pop; honoured only when FIFOValid=1
RdData  input  DataWidth  RAM read data, valid the cycle after RdEn
RdEn  output  1  RAM read enable
RdAddr  output  AddrLines  RAM read address = SyncRdAddr[AddrLines-1:0]
SyncRdAddr  output  AddrLines+1  read pointer to write controller
FIFODout  output  DataWidth  head-of-FIFO data (FWFT)
FIFOValid  output  1  FIFODout holds valid data (complement of consumer-visible empty)
FIFOEmpty  output  1  = !FIFOValid
MemCount  output  AddrLines+1  words in RAM not yet read = SyncWrAddr - SyncRdAddr, modulo 2**(AddrLines+1)

Behaviour:
- Reset (reset==0 at posedge): SyncRdAddr=0, RdPend=0, FIFOValid=0, SkidValid=0, FIFODout=0, skid data=0. RdEn is then 0 because it is gated by reset. Reset overrides every other event in the same cycle.
- MemEmpty = (SyncWrAddr == SyncRdAddr), full AddrLines+1-bit compare. Wrap-bit difference means not empty.
- Pop = FIFORdReq && FIFOValid. FIFORdReq while FIFOValid=0 is ignored with no side effects.
- Occupancy Occ = FIFOValid + SkidValid + RdPend, range 0..2.
- RdEn = reset && !MemEmpty && ((Occ - Pop) < 2). Combinational.
- On RdEn: SyncRdAddr <= SyncRdAddr+1, wrapping naturally at 2**(AddrLines+1). RdPend <= RdEn every cycle.
- Data landing when RdPend=1 (RdData valid this cycle):
  - if FIFOValid=0, or (Pop and SkidValid=0): FIFODout <= RdData, FIFOValid <= 1
  - else: skid <= RdData, SkidValid <= 1
- Pop without landing: if SkidValid, FIFODout <= skid, SkidValid <= 0; else FIFOValid <= 0.
- Pop with landing and SkidValid=1: FIFODout <= skid, skid <= RdData. SkidValid stays 1.
- Ordering invariant: the skid is never valid while FIFOValid=0.
- Latency: first write visible in SyncWrAddr at cycle N gives RdEn at N and FIFOValid=1 at N+2.
- Throughput: continuous pop with a non-empty RAM gives one word per cycle with no bubbles.
- Backpressure: with FIFORdReq=0, at most 2 words are held outside the RAM, then RdEn stops.
- Simultaneous write (SyncWrAddr change) and read: the pointer compare uses registered values only, with no combinational path from write-side inputs other than SyncWrAddr.
- SyncRdAddr advances at read issue, so the RAM slot is released to the writer one cycle after the read. The RAM is read-first and registered, so there is no hazard.

Decomposition:
- Shared package sfifo_pkg holds:
  - default AddrLines/DataWidth
  - pointer-width constant (AddrLines+1)
  - function ptr_count(wr, rd) returning the modulo difference, reused by the write side for a free count
- One natural sub-module: sfifo_out_stage, the FWFT head register plus skid with its valid/pop logic. The pointer/RdEn logic stays in the top.

Test Plan:
1. Reset: hold reset=0 for 3 clk with SyncWrAddr=5 -> RdEn=0, SyncRdAddr=0, FIFOValid=0, FIFOEmpty=1, MemCount=5. After release -> RdEn=1 on the first cycle.
2. Single word: SyncWrAddr 0->1 at cycle N, RdData=0xA5 at N+1 -> RdEn=1 at N only; FIFOValid=1 with FIFODout=0xA5 at N+2; pop at N+2 -> FIFOValid=0 at N+3; SyncRdAddr=1.
3. Streaming: 16 words preloaded, FIFORdReq=1 constantly -> 16 consecutive valid words in order, no bubble, SyncRdAddr=16, FIFOEmpty=1 afterwards.
4. Backpressure: 10 words preloaded, FIFORdReq=0 -> exactly 2 RdEn pulses, SyncRdAddr=2, MemCount=8. Then pop every other cycle -> data order preserved and Occ never exceeds 2.
5. Wrap (AddrLines=3): stream 20 words through -> SyncRdAddr passes 15->0, MemEmpty is asserted only at a true pointer match, and RdAddr wraps 7->0.
6. Reset mid-operation: reset=0 while FIFOValid=1, SkidValid=1, RdPend=1 -> all state cleared next edge, RdEn=0 during reset, and no stale word is presented after release.
